// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the register-file write-back controller.
//   NREG/AW/DW   : register count, address width, data width
//   CW           : pending-write counter width (max outstanding = 2**CW-1)
//   STARVE_MAX   : consecutive contested LSU wins before ALU is forced a grant
//   wb_req_t     : one write-back request {rd, data}
//   wb_src_e     : which requester won the write port
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int NREG       = 32;
  localparam int AW         = 5;
  localparam int DW         = 32;
  localparam int CW         = 2;
  localparam int STARVE_MAX = 3;

  // Saturation value of a pending-write counter
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_req_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

  // x0 is hardwired zero: it never has a pending write
  function automatic logic is_x0(input logic [AW-1:0] rd);
    return (rd == {AW{1'b0}});
  endfunction

endpackage

// File: rtl/wb_prio_arbiter.sv
// ---------------------------------------------------------------------------
// wb_prio_arbiter
// Two-input priority arbiter for the register-file write port. LSU has
// priority under contention, but after STARVE_LIM consecutive contested LSU
// wins the ALU is forced one grant.
// Ports:
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_alu_valid           : ALU request
//   i_lsu_valid           : LSU request
//   o_alu_gnt, o_lsu_gnt  : one-hot (or zero) grants, combinational
//   o_src                 : winning source (meaningful only when a grant is set)
// ---------------------------------------------------------------------------
module wb_prio_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_LIM = STARVE_MAX
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  logic    i_alu_valid,
  input  logic    i_lsu_valid,
  output logic    o_alu_gnt,
  output logic    o_lsu_gnt,
  output wb_src_e o_src
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIM);

  logic [SW-1:0] r_starve;
  logic          w_contested;
  logic          w_force_alu;

  // Grant decode: lone requester wins, LSU wins contention unless ALU is starved
  always_comb begin
    w_contested = i_alu_valid & i_lsu_valid;
    w_force_alu = (r_starve == STARVE_TOP);
    o_alu_gnt   = i_alu_valid & (~i_lsu_valid | w_force_alu);
    o_lsu_gnt   = i_lsu_valid & ~o_alu_gnt;
    if (o_alu_gnt) begin
      o_src = WB_ALU;
    end else begin
      o_src = WB_LSU;
    end
  end

  // Starve counter: counts contested LSU wins, cleared by anything else
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve <= {SW{1'b0}};
    end else if (w_contested && o_lsu_gnt) begin
      if (r_starve != STARVE_TOP) begin
        r_starve <= r_starve + SW'(1);
      end else begin
        r_starve <= r_starve;
      end
    end else begin
      r_starve <= {SW{1'b0}};
    end
  end

endmodule

// File: rtl/regfile_wb_controller.sv
// ---------------------------------------------------------------------------
// regfile_wb_controller
// Write-back controller for the 32x32 2R1W register file. Arbitrates the
// write port between ALU and LSU, registers the winning write (one-cycle
// latency) and keeps per-register pending-write counters for RAW detection.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   alu_valid/ready/rd/data         : ALU write-back handshake
//   lsu_valid/ready/rd/data         : LSU write-back handshake
//   rsv_valid/ready/rd              : destination reservation from issue
//   rs1, rs2 / rs1_busy, rs2_busy   : hazard query (combinational)
//   rf_a3, rf_wd, rf_wen            : registered register-file write port
//   err_uflow                       : sticky, write-back with no pending count
// Configuration macro WB_BYPASS_EN adds rs1_fwd/rs2_fwd and
// rs1_fwd_data/rs2_fwd_data, forwarding the write currently on the RF port
// and releasing busy when that write retires the last pending count.
// ---------------------------------------------------------------------------
module regfile_wb_controller
  import regfile_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic [AW-1:0] lsu_rd,
  input  logic [DW-1:0] lsu_data,
  input  logic          rsv_valid,
  output logic          rsv_ready,
  input  logic [AW-1:0] rsv_rd,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic [AW-1:0] rf_a3,
  output logic [DW-1:0] rf_wd,
  output logic          rf_wen,
  output logic          err_uflow
`ifdef WB_BYPASS_EN
  ,
  output logic          rs1_fwd,
  output logic          rs2_fwd,
  output logic [DW-1:0] rs1_fwd_data,
  output logic [DW-1:0] rs2_fwd_data
`endif
);

  logic          w_alu_gnt;
  logic          w_lsu_gnt;
  wb_src_e       w_src;
  wb_req_t       w_alu_req;
  wb_req_t       w_lsu_req;
  wb_req_t       w_win_req;
  logic          w_xfer;
  logic          w_rsv_fire;
  logic          w_uflow;
  logic          w_inc [NREG];
  logic          w_dec [NREG];
  logic [CW-1:0] w_cnt_nxt [NREG];
  logic          w_rs1_pend;
  logic          w_rs2_pend;

  logic          r_rf_wen;
  logic [AW-1:0] r_rf_a3;
  logic [DW-1:0] r_rf_wd;
  logic          r_err_uflow;
  logic [CW-1:0] r_cnt [NREG];

  wb_prio_arbiter #(
    .STARVE_LIM (STARVE_MAX)
  ) u_arb (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_alu_valid (alu_valid),
    .i_lsu_valid (lsu_valid),
    .o_alu_gnt   (w_alu_gnt),
    .o_lsu_gnt   (w_lsu_gnt),
    .o_src       (w_src)
  );

  assign alu_ready = w_alu_gnt;
  assign lsu_ready = w_lsu_gnt;
  assign w_alu_req = '{rd: alu_rd, data: alu_data};
  assign w_lsu_req = '{rd: lsu_rd, data: lsu_data};

  // Winner mux for the write-port request
  always_comb begin
    w_xfer = w_alu_gnt | w_lsu_gnt;
    if (w_src == WB_ALU) begin
      w_win_req = w_alu_req;
    end else begin
      w_win_req = w_lsu_req;
    end
  end

  // Registered write port; a transfer to x0 completes but never writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_wen <= 1'b0;
      r_rf_a3  <= {AW{1'b0}};
      r_rf_wd  <= {DW{1'b0}};
    end else begin
      r_rf_wen <= w_xfer & ~is_x0(w_win_req.rd);
      if (w_xfer && !is_x0(w_win_req.rd)) begin
        r_rf_a3 <= w_win_req.rd;
        r_rf_wd <= w_win_req.data;
      end else begin
        r_rf_a3 <= r_rf_a3;
        r_rf_wd <= r_rf_wd;
      end
    end
  end

  assign rf_wen    = r_rf_wen;
  assign rf_a3     = r_rf_a3;
  assign rf_wd     = r_rf_wd;
  assign err_uflow = r_err_uflow;

  // A saturated counter refuses further reservations; x0 always accepts
  assign rsv_ready  = is_x0(rsv_rd) | (r_cnt[rsv_rd] != CNT_MAX);
  assign w_rsv_fire = rsv_valid & rsv_ready;

  // Next-state for every pending counter; same-edge inc+dec cancel out
  always_comb begin
    w_uflow = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      w_inc[i]     = w_rsv_fire & (rsv_rd == AW'(i));
      w_dec[i]     = r_rf_wen & (r_rf_a3 == AW'(i));
      w_cnt_nxt[i] = r_cnt[i];
      if (i == 0) begin
        w_cnt_nxt[i] = {CW{1'b0}};
      end else if (w_inc[i] && !w_dec[i]) begin
        w_cnt_nxt[i] = r_cnt[i] + CW'(1);
      end else if (w_dec[i] && !w_inc[i]) begin
        if (r_cnt[i] == {CW{1'b0}}) begin
          w_uflow = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] - CW'(1);
        end
      end else begin
        w_cnt_nxt[i] = r_cnt[i];
      end
    end
  end

  // Pending counter array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= {CW{1'b0}};
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  // Sticky underflow flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_uflow <= 1'b0;
    end else if (w_uflow) begin
      r_err_uflow <= 1'b1;
    end else begin
      r_err_uflow <= r_err_uflow;
    end
  end

  assign w_rs1_pend = ~is_x0(rs1) & (r_cnt[rs1] != {CW{1'b0}});
  assign w_rs2_pend = ~is_x0(rs2) & (r_cnt[rs2] != {CW{1'b0}});

`ifdef WB_BYPASS_EN
  logic w_rs1_hit;
  logic w_rs2_hit;

  // Forward the in-flight write; release busy if it retires the last count
  always_comb begin
    w_rs1_hit = r_rf_wen & (r_rf_a3 == rs1) & ~is_x0(rs1);
    w_rs2_hit = r_rf_wen & (r_rf_a3 == rs2) & ~is_x0(rs2);
    rs1_fwd   = w_rs1_hit;
    rs2_fwd   = w_rs2_hit;
    if (w_rs1_hit) begin
      rs1_fwd_data = r_rf_wd;
    end else begin
      rs1_fwd_data = {DW{1'b0}};
    end
    if (w_rs2_hit) begin
      rs2_fwd_data = r_rf_wd;
    end else begin
      rs2_fwd_data = {DW{1'b0}};
    end
    rs1_busy = w_rs1_pend & ~(w_rs1_hit & (r_cnt[rs1] == CW'(1)));
    rs2_busy = w_rs2_pend & ~(w_rs2_hit & (r_cnt[rs2] == CW'(1)));
  end
`else
  assign rs1_busy = w_rs1_pend;
  assign rs2_busy = w_rs2_pend;
`endif

endmodule

// File: tb/tb_regfile_wb_controller.sv
// Directed bench for regfile_wb_controller: write latency, arbitration with
// starvation relief, reservation saturation, hazard tracking, x0 handling,
// underflow and asynchronous reset.
module tb_regfile_wb_controller;

  logic        clk;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        rsv_valid, rsv_ready;
  logic [4:0]  rsv_rd;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic        rf_wen;
  logic        err_uflow;
`ifdef WB_BYPASS_EN
  logic        rs1_fwd, rs2_fwd;
  logic [31:0] rs1_fwd_data, rs2_fwd_data;
`endif

  int n_chk = 0;
  int n_err = 0;

  regfile_wb_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .rsv_valid (rsv_valid),
    .rsv_ready (rsv_ready),
    .rsv_rd    (rsv_rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .rf_a3     (rf_a3),
    .rf_wd     (rf_wd),
    .rf_wen    (rf_wen),
    .err_uflow (err_uflow)
`ifdef WB_BYPASS_EN
    ,
    .rs1_fwd      (rs1_fwd),
    .rs2_fwd      (rs2_fwd),
    .rs1_fwd_data (rs1_fwd_data),
    .rs2_fwd_data (rs2_fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reserve(input logic [4:0] rd);
    rsv_valid = 1'b1;
    rsv_rd    = rd;
    tick();
    rsv_valid = 1'b0;
  endtask

  logic [4:0] lsu_pat;

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
    rsv_valid = 1'b0; rsv_rd = 5'd0;
    rs1 = 5'd0; rs2 = 5'd0;
    tick();
    tick();
    check("rst_wen", {31'd0, rf_wen}, 32'd0);
    check("rst_a3", {27'd0, rf_a3}, 32'd0);
    check("rst_wd", rf_wd, 32'd0);
    check("rst_err", {31'd0, err_uflow}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_alu_rdy", {31'd0, alu_ready}, 32'd0);
    check("idle_rsv_rdy", {31'd0, rsv_ready}, 32'd1);

    // Lone ALU write to x5 (reserved first so no underflow)
    reserve(5'd5);
    rs1 = 5'd5;
    #1 check("x5_busy", {31'd0, rs1_busy}, 32'd1);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1 check("lone_alu_rdy", {31'd0, alu_ready}, 32'd1);
    check("lone_lsu_rdy", {31'd0, lsu_ready}, 32'd0);
    tick();
    alu_valid = 1'b0;
    check("lone_wen", {31'd0, rf_wen}, 32'd1);
    check("lone_a3", {27'd0, rf_a3}, 32'd5);
    check("lone_wd", rf_wd, 32'hDEADBEEF);
    tick();
    check("lone_wen_off", {31'd0, rf_wen}, 32'd0);
    check("x5_free", {31'd0, rs1_busy}, 32'd0);
    check("lone_err", {31'd0, err_uflow}, 32'd0);

    // Contention held five cycles: LSU,LSU,LSU,ALU,LSU (bit i = LSU wins)
    lsu_pat = 5'b10111;
    for (int i = 0; i < 5; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h100 + i;
      lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h200 + i;
      #1;
      check($sformatf("cont%0d_lsu", i), {31'd0, lsu_ready}, {31'd0, lsu_pat[i]});
      check($sformatf("cont%0d_alu", i), {31'd0, alu_ready}, {31'd0, ~lsu_pat[i]});
      tick();
      check($sformatf("cont%0d_x0wen", i), {31'd0, rf_wen}, 32'd0);
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;

    // Reserve x7 to saturation
    for (int i = 0; i < 3; i++) begin
      rsv_valid = 1'b1; rsv_rd = 5'd7;
      #1 check($sformatf("rsv7_%0d", i), {31'd0, rsv_ready}, 32'd1);
      tick();
    end
    #1 check("rsv7_sat", {31'd0, rsv_ready}, 32'd0);
    tick();
    rsv_valid = 1'b0;
    rs1 = 5'd7;
    #1 check("x7_busy", {31'd0, rs1_busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h70 + i;
      #1 check($sformatf("wb7_%0d_rdy", i), {31'd0, alu_ready}, 32'd1);
      tick();
    end
    alu_valid = 1'b0;
    check("wb7_last_a3", {27'd0, rf_a3}, 32'd7);
    check("wb7_last_wd", rf_wd, 32'h72);
`ifdef WB_BYPASS_EN
    check("wb7_last_busy", {31'd0, rs1_busy}, 32'd0);
`else
    check("wb7_last_busy", {31'd0, rs1_busy}, 32'd1);
`endif
    tick();
    check("x7_free", {31'd0, rs1_busy}, 32'd0);
    check("x7_err", {31'd0, err_uflow}, 32'd0);

    // Same-edge reservation and commit on x9
    reserve(5'd9);
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    tick();
    alu_valid = 1'b0;
    rsv_valid = 1'b1; rsv_rd = 5'd9; rs2 = 5'd9;
    #1 check("x9_wen", {31'd0, rf_wen}, 32'd1);
    check("x9_rsv_rdy", {31'd0, rsv_ready}, 32'd1);
    tick();
    rsv_valid = 1'b0;
    check("x9_busy", {31'd0, rs2_busy}, 32'd1);
    check("x9_err", {31'd0, err_uflow}, 32'd0);

    // Write-back to x0, then to x4 with nothing pending
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    tick();
    alu_valid = 1'b0;
    check("x0_wen", {31'd0, rf_wen}, 32'd0);
    check("x0_err", {31'd0, err_uflow}, 32'd0);
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h12345678;
    #1 check("x4_lsu_rdy", {31'd0, lsu_ready}, 32'd1);
    tick();
    lsu_valid = 1'b0;
    check("x4_wen", {31'd0, rf_wen}, 32'd1);
    check("x4_a3", {27'd0, rf_a3}, 32'd4);
    check("x4_wd", rf_wd, 32'h12345678);
    tick();
    check("uflow_set", {31'd0, err_uflow}, 32'd1);
    tick();
    check("uflow_sticky", {31'd0, err_uflow}, 32'd1);

    // Hazard on the commit cycle of x11 (forwarded when bypass is built in)
    reserve(5'd11);
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hCAFEF00D;
    tick();
    alu_valid = 1'b0;
    rs1 = 5'd11;
    #1 check("x11_wen", {31'd0, rf_wen}, 32'd1);
`ifdef WB_BYPASS_EN
    check("x11_fwd", {31'd0, rs1_fwd}, 32'd1);
    check("x11_fwd_data", rs1_fwd_data, 32'hCAFEF00D);
    check("x11_busy", {31'd0, rs1_busy}, 32'd0);
    check("x9_nofwd", {31'd0, rs2_fwd}, 32'd0);
`else
    check("x11_busy", {31'd0, rs1_busy}, 32'd1);
`endif
    tick();
    check("x11_free", {31'd0, rs1_busy}, 32'd0);

    // Asynchronous reset in the middle of a registered write
    reserve(5'd3);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    tick();
    alu_valid = 1'b0;
    check("pre_rst_wen", {31'd0, rf_wen}, 32'd1);
    check("pre_rst_x9", {31'd0, rs2_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_wen", {31'd0, rf_wen}, 32'd0);
    check("mid_rst_a3", {27'd0, rf_a3}, 32'd0);
    check("mid_rst_wd", rf_wd, 32'd0);
    check("mid_rst_x9", {31'd0, rs2_busy}, 32'd0);
    check("mid_rst_err", {31'd0, err_uflow}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_wen", {31'd0, rf_wen}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
